// File: rtl/fpga_mbox_sram_arb_if.sv
// Debug requester channel between the realtime register block and the
// mailbox SRAM arbiter: a valid/ready request path and a valid/ready
// response path.
//   master : debug requester (drives requests, consumes responses)
//   slave  : arbiter (accepts requests, produces responses)
interface fpga_mbox_sram_arb_if #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 39
) ();

   logic              dbg_req_valid;
   logic              dbg_req_ready;
   logic              dbg_req_we;
   logic [ADDR_W-1:0] dbg_req_addr;
   logic [DATA_W-1:0] dbg_req_wdata;

   logic              dbg_rsp_valid;
   logic              dbg_rsp_ready;
   logic [DATA_W-1:0] dbg_rsp_rdata;
   logic              dbg_rsp_was_write;

   modport master (
      output dbg_req_valid,
      output dbg_req_we,
      output dbg_req_addr,
      output dbg_req_wdata,
      output dbg_rsp_ready,
      input  dbg_req_ready,
      input  dbg_rsp_valid,
      input  dbg_rsp_rdata,
      input  dbg_rsp_was_write
   );

   modport slave (
      input  dbg_req_valid,
      input  dbg_req_we,
      input  dbg_req_addr,
      input  dbg_req_wdata,
      input  dbg_rsp_ready,
      output dbg_req_ready,
      output dbg_rsp_valid,
      output dbg_rsp_rdata,
      output dbg_rsp_was_write
   );

endinterface

// File: rtl/fpga_mbox_sram_arb.sv
// Mailbox SRAM arbiter between Caliptra and an FPGA-side debug requester.
// Caliptra owns the SRAM with absolute priority and zero added latency; the
// debug requester gets the SRAM only in cycles Caliptra leaves idle, with a
// single transaction in flight.
// Ports:
//   core_clk, rst         clock, asynchronous active-high reset
//   cptra_*               Caliptra SRAM port (combinational pass-through)
//   dbg                   debug request/response channel (slave side)
//   dbg_enable            gates acceptance of new debug requests
//   conflict_cnt/_clr     saturating count of debug cycles blocked by Caliptra
//   sram_*                physical SRAM port
module fpga_mbox_sram_arb #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 39,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                core_clk,
   input  logic                rst,

   input  logic                cptra_cs,
   input  logic                cptra_we,
   input  logic [ADDR_W-1:0]   cptra_addr,
   input  logic [DATA_W-1:0]   cptra_wdata,
   output logic [DATA_W-1:0]   cptra_rdata,

   fpga_mbox_sram_arb_if.slave dbg,
   input  logic                dbg_enable,

   output logic [15:0]         conflict_cnt,
   input  logic                conflict_clr,

   output logic                sram_cs,
   output logic                sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   localparam int unsigned CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam int unsigned CONF_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LATENCY - 1);
   localparam logic [CONF_W-1:0] CONF_MAX = {CONF_W{1'b1}};

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_was_write_q, rsp_was_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [CONF_W-1:0] conflict_q, conflict_d;

   logic              req_ready_c;
   logic              req_fire_c;
   logic              blocked_c;

   // Acceptance only when idle, enabled, and Caliptra is not using the SRAM.
   assign req_ready_c = (state_q == ST_IDLE) & dbg_enable & ~cptra_cs & ~rst;
   assign req_fire_c  = dbg.dbg_req_valid & req_ready_c;
   assign blocked_c   = (state_q == ST_IDLE) & dbg_enable & dbg.dbg_req_valid & cptra_cs;

   assign dbg.dbg_req_ready     = req_ready_c;
   assign dbg.dbg_rsp_valid     = rsp_valid_q;
   assign dbg.dbg_rsp_rdata     = rsp_rdata_q;
   assign dbg.dbg_rsp_was_write = rsp_was_write_q;
   assign conflict_cnt          = conflict_q;

   // Caliptra always sees the raw SRAM read data.
   assign cptra_rdata = sram_rdata;

   // SRAM port mux: Caliptra first, then an accepted debug op, else idle.
   always_comb begin
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (cptra_cs) begin
         sram_cs    = 1'b1;
         sram_we    = cptra_we;
         sram_addr  = cptra_addr;
         sram_wdata = cptra_wdata;
      end else if (req_fire_c) begin
         sram_cs    = 1'b1;
         sram_we    = dbg.dbg_req_we;
         sram_addr  = dbg.dbg_req_addr;
         sram_wdata = dbg.dbg_req_wdata;
      end
   end

   // Debug transaction FSM. WAIT counts down so that the capture edge falls
   // exactly RD_LATENCY cycles after issue; with RD_LATENCY=1 the counter
   // starts at zero and WAIT is itself the capture cycle. Caliptra traffic
   // after issue does not disturb the capture because the SRAM returns data
   // in issue order.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      we_d            = we_q;
      rsp_valid_d     = rsp_valid_q;
      rsp_was_write_d = rsp_was_write_q;
      rsp_rdata_d     = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_fire_c) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_INIT;
               we_d    = dbg.dbg_req_we;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d         = ST_RESP;
               rsp_valid_d     = 1'b1;
               rsp_was_write_d = we_q;
               rsp_rdata_d     = we_q ? '0 : sram_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (dbg.dbg_rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Blocked-cycle counter; clear wins over increment, saturates at max.
   always_comb begin
      conflict_d = conflict_q;
      if (conflict_clr) begin
         conflict_d = '0;
      end else if (blocked_c && (conflict_q != CONF_MAX)) begin
         conflict_d = conflict_q + CONF_W'(1);
      end
   end

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         we_q            <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_was_write_q <= 1'b0;
         rsp_rdata_q     <= '0;
         conflict_q      <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         we_q            <= we_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_was_write_q <= rsp_was_write_d;
         rsp_rdata_q     <= rsp_rdata_d;
         conflict_q      <= conflict_d;
      end
   end

endmodule
